// File: rtl/smg_scan_scheduler.sv
// smg_scan_scheduler: tear-free round-robin seven-segment scan; define SMG_BLANK_EN for an anti-ghost blank gap before every digit.
module smg_scan_scheduler #(
  parameter int          DIGITS  = 4,
  parameter logic [18:0] DWELL   = 19'd49_999,
  parameter logic [11:0] BLANK   = 12'd2_499,
  parameter logic [7:0]  SEG_OFF = 8'hFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [8*DIGITS-1:0]   Digit_Data,
  input  logic [DIGITS-1:0]     Digit_Enable,
  output logic [7:0]            Row_Scan_Sig,
  output logic [DIGITS-1:0]     Column_Scan_Sig,
  output logic                  Frame_Sync
);
  localparam int IW = $clog2(DIGITS);
  localparam int DW = $clog2(int'(DWELL) + 2);
  localparam logic [DW-1:0] DWELL_C = DW'(DWELL);
`ifdef SMG_BLANK_EN
  localparam int BW = $clog2(int'(BLANK) + 2);
  localparam logic [BW-1:0] BLANK_C = BW'(BLANK);
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
  localparam state_t S_START = S_BLANK;
  logic [BW-1:0] bcnt_q, bcnt_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHOW} state_t;
  localparam state_t S_START = S_SHOW;
`endif
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, up_idx, fresh_idx;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [8*DIGITS-1:0] sh_data_q;
  logic [DIGITS-1:0] sh_en_q, col_q, col_d;
  logic [7:0] row_q, row_d;
  logic fs_q, fs_d, snap, up_found;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
`ifdef SMG_BLANK_EN
      bcnt_q    <= '0;
`endif
      sh_data_q <= '0;
      sh_en_q   <= '0;
      col_q     <= '1;
      row_q     <= SEG_OFF;
      fs_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef SMG_BLANK_EN
      bcnt_q  <= bcnt_d;
`endif
      col_q   <= col_d;
      row_q   <= row_d;
      fs_q    <= fs_d;
      if (snap) begin
        sh_data_q <= Digit_Data;
        sh_en_q   <= Digit_Enable;
      end
    end
  end
  // A wrap (no enabled digit above the current one) closes the frame and resamples the inputs.
  always_comb begin
    up_found  = 1'b0;
    up_idx    = '0;
    fresh_idx = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (sh_en_q[k] && k > int'(idx_q)) begin
        up_found = 1'b1;
        up_idx   = IW'(k);
      end
      if (Digit_Enable[k]) fresh_idx = IW'(k);
    end
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap    = 1'b0;
`ifdef SMG_BLANK_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        snap = 1'b1;
        if (|Digit_Enable) begin
          state_d = S_START;
          idx_d   = fresh_idx;
          cnt_d   = '0;
        end
      end
`ifdef SMG_BLANK_EN
      S_BLANK: begin
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BLANK_C) begin
          state_d = S_SHOW;
          bcnt_d  = '0;
          cnt_d   = '0;
        end
      end
`endif
      S_SHOW: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DWELL_C) begin
          cnt_d = '0;
          snap  = !up_found;
          state_d = (up_found || |Digit_Enable) ? S_START : S_IDLE;
          idx_d   = up_found ? up_idx : (|Digit_Enable ? fresh_idx : '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    col_d = (state_q == S_SHOW) ? ~(DIGITS'(1) << idx_q) : '1;
    row_d = (state_q == S_SHOW) ? sh_data_q[8*idx_q +: 8] : SEG_OFF;
    fs_d  = snap;
  end
  assign Row_Scan_Sig    = row_q;
  assign Column_Scan_Sig = col_q;
  assign Frame_Sync      = fs_q;
endmodule

// File: tb/tb_smg_scan_scheduler.sv
// tb_smg_scan_scheduler: directed checks of scan order, frame timing, tear-free snapshots and reset, with or without SMG_BLANK_EN.
module tb_smg_scan_scheduler;
`ifdef SMG_BLANK_EN
  localparam int BL = 3;
`else
  localparam int BL = 0;
`endif
  localparam int P = BL + 10;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] data;
  logic [3:0] en, col;
  logic [7:0] row;
  logic fs;
  int n_chk = 0, n_fail = 0;
  logic [3:0] col_a [0:255];
  logic [7:0] row_a [0:255];
  logic fs_a [0:255];
  bit cap_ok;
  always #5 clk = ~clk;
  smg_scan_scheduler #(.DIGITS(4), .DWELL(19'd9), .BLANK(12'd2), .SEG_OFF(8'hFF)) dut (
    .CLK(clk), .RST(rst), .Digit_Data(data), .Digit_Enable(en),
    .Row_Scan_Sig(row), .Column_Scan_Sig(col), .Frame_Sync(fs)
  );
  function automatic logic [3:0] ecol(int k, int o);
    return (o < BL) ? 4'hF : ~(4'b0001 << k);
  endfunction
  function automatic logic [7:0] erow(logic [31:0] d, int k, int o);
    return (o < BL) ? 8'hFF : d[k*8 +: 8];
  endfunction
  // Sample n cycles starting at the next Frame_Sync; optionally change inputs after sample chg_at.
  task automatic capture(input int n, input int chg_at, input logic [31:0] chg_data, input logic [3:0] chg_en);
    int w = 0;
    cap_ok = 1'b0;
    while (w < 200 && !cap_ok) begin
      @(negedge clk);
      w++;
      cap_ok = (fs === 1'b1);
    end
    if (cap_ok)
      for (int j = 0; j < n; j++) begin
        col_a[j] = col;
        row_a[j] = row;
        fs_a[j]  = fs;
        if (j == chg_at) begin
          data = chg_data;
          en   = chg_en;
        end
        @(negedge clk);
      end
  endtask
  task automatic test_reset();
    data = 32'h0; en = 4'h0; rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (col !== 4'hF || row !== 8'hFF || fs !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: col=%h row=%h fs=%b, want F FF 0", col, row, fs);
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (col !== 4'hF || row !== 8'hFF || fs !== 1'b1) begin
      n_fail++;
      $display("FAIL idle: col=%h row=%h fs=%b, want F FF 1", col, row, fs);
    end
  endtask
  task automatic test_full_scan();
    int s, o, k;
    data = 32'h11223344; en = 4'hF;
    capture(8*P + 1, -1, data, en);
    n_chk++;
    if (!cap_ok) begin n_fail++; $display("FAIL full_scan: no Frame_Sync, want one within 200 cycles"); end
    for (int j = 1; j <= 8*P && cap_ok; j++) begin
      s = (j-1)/P; o = (j-1)%P; k = s%4;
      n_chk++;
      if (col_a[j] !== ecol(k, o) || row_a[j] !== erow(32'h11223344, k, o)) begin
        n_fail++;
        $display("FAIL full_scan j=%0d: col/row=%h/%h want %h/%h", j, col_a[j], row_a[j], ecol(k, o), erow(32'h11223344, k, o));
      end
      n_chk++;
      if (fs_a[j] !== (j % (4*P) == 0)) begin
        n_fail++;
        $display("FAIL full_scan sync j=%0d: fs=%b want %b", j, fs_a[j], j % (4*P) == 0);
      end
    end
  endtask
  task automatic test_tear_free();
    int s, o, k;
    logic [31:0] d;
    data = 32'h11223344; en = 4'hF;
    capture(8*P + 1, P + BL + 5, 32'hAABBCCDD, 4'hF);
    n_chk++;
    if (!cap_ok) begin n_fail++; $display("FAIL tear_free: no Frame_Sync, want one within 200 cycles"); end
    for (int j = 1; j <= 8*P && cap_ok; j++) begin
      s = (j-1)/P; o = (j-1)%P; k = s%4;
      d = (s < 4) ? 32'h11223344 : 32'hAABBCCDD;
      n_chk++;
      if (col_a[j] !== ecol(k, o) || row_a[j] !== erow(d, k, o)) begin
        n_fail++;
        $display("FAIL tear_free j=%0d: col/row=%h/%h want %h/%h", j, col_a[j], row_a[j], ecol(k, o), erow(d, k, o));
      end
      n_chk++;
      if (fs_a[j] !== (j % (4*P) == 0)) begin
        n_fail++;
        $display("FAIL tear_free sync j=%0d: fs=%b want %b", j, fs_a[j], j % (4*P) == 0);
      end
    end
  endtask
  task automatic test_sparse();
    int s, o, k;
    data = 32'h11223344; en = 4'b1010;
    capture(4*P + 1, -1, data, en);
    n_chk++;
    if (!cap_ok) begin n_fail++; $display("FAIL sparse: no Frame_Sync, want one within 200 cycles"); end
    for (int j = 1; j <= 4*P && cap_ok; j++) begin
      s = (j-1)/P; o = (j-1)%P; k = (s%2 == 1) ? 3 : 1;
      n_chk++;
      if (col_a[j] !== ecol(k, o) || row_a[j] !== erow(32'h11223344, k, o)) begin
        n_fail++;
        $display("FAIL sparse j=%0d: col/row=%h/%h want %h/%h", j, col_a[j], row_a[j], ecol(k, o), erow(32'h11223344, k, o));
      end
      n_chk++;
      if (fs_a[j] !== (j % (2*P) == 0)) begin
        n_fail++;
        $display("FAIL sparse sync j=%0d: fs=%b want %b", j, fs_a[j], j % (2*P) == 0);
      end
    end
  endtask
  task automatic test_enable_zero();
    int s, o, k;
    data = 32'h11223344; en = 4'hF;
    capture(4*P + 6, 5, data, 4'h0);
    n_chk++;
    if (!cap_ok) begin n_fail++; $display("FAIL en_zero: no Frame_Sync, want one within 200 cycles"); end
    for (int j = 1; j < 4*P + 6 && cap_ok; j++) begin
      s = (j-1)/P; o = (j-1)%P; k = s%4;
      n_chk++;
      if (j <= 4*P && (col_a[j] !== ecol(k, o) || row_a[j] !== erow(32'h11223344, k, o))) begin
        n_fail++;
        $display("FAIL en_zero frame j=%0d: col/row=%h/%h want %h/%h", j, col_a[j], row_a[j], ecol(k, o), erow(32'h11223344, k, o));
      end else if (j > 4*P && (col_a[j] !== 4'hF || row_a[j] !== 8'hFF || fs_a[j] !== 1'b1)) begin
        n_fail++;
        $display("FAIL en_zero idle j=%0d: col/row/fs=%h/%h/%b want F/FF/1", j, col_a[j], row_a[j], fs_a[j]);
      end
      n_chk++;
      if (fs_a[j] !== (j >= 4*P)) begin
        n_fail++;
        $display("FAIL en_zero sync j=%0d: fs=%b want %b", j, fs_a[j], j >= 4*P);
      end
    end
    en = 4'b0100;
    capture(3*P + 1, -1, data, en);
    n_chk++;
    if (!cap_ok) begin n_fail++; $display("FAIL single: no Frame_Sync, want one within 200 cycles"); end
    for (int j = 1; j <= 3*P && cap_ok; j++) begin
      o = (j-1)%P;
      n_chk++;
      if (col_a[j] !== ecol(2, o) || row_a[j] !== erow(32'h11223344, 2, o) || fs_a[j] !== (j % P == 0)) begin
        n_fail++;
        $display("FAIL single j=%0d: col/row/fs=%h/%h/%b want %h/%h/%b", j, col_a[j], row_a[j], fs_a[j], ecol(2, o), erow(32'h11223344, 2, o), j % P == 0);
      end
    end
  endtask
  task automatic test_reset_mid();
    data = 32'h11223344; en = 4'hF;
    capture(BL + 4, -1, data, en);
    n_chk++;
    if (!cap_ok || col !== 4'b1110 || row !== 8'h44) begin
      n_fail++;
      $display("FAIL reset_mid pre: col/row=%h/%h want e/44", col, row);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (col !== 4'hF || row !== 8'hFF || fs !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: col/row/fs=%h/%h/%b want F/FF/0", i, col, row, fs);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (col !== 4'hF || row !== 8'hFF || fs !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid release: col/row/fs=%h/%h/%b want F/FF/1", col, row, fs);
    end
  endtask
  initial begin
    test_reset();
    test_full_scan();
    test_tear_free();
    test_sparse();
    test_enable_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
